// File: rtl/vec_uart_pkg.sv
// Shared definitions for the vector coprocessor UART link: byte framing
// constants, read-back FSM states and word-to-byte split helpers.
package vec_uart_pkg;

  localparam int         WORD_W     = 10;
  localparam logic [7:0] END_MARKER = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    SEND_LO,
    SEND_HI,
    END_LO,
    END_HI,
    DONE
  } tx_state_t;

  function automatic logic [7:0] lo_byte(input logic [WORD_W-1:0] w);
    return w[7:0];
  endfunction

  // High byte carries only two payload bits, so it can never equal END_MARKER.
  function automatic logic [7:0] hi_byte(input logic [WORD_W-1:0] w);
    return {6'b0, w[9:8]};
  endfunction

endpackage

// File: rtl/fsm_split_tx.sv
// Read-back path: fetches result words from BRAM, sends each as a low/high
// byte pair to the UART transmitter and closes the stream with 0xFF, 0xFF.
module fsm_split_tx
  import vec_uart_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int WORD_W     = vec_uart_pkg::WORD_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [WORD_W-1:0] bram_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output tx_state_t         state_dbg
);

  // Handshake: a byte moves on any cycle with tx_valid && tx_ready. Once
  // tx_valid rises, tx_valid and tx_data are held until that cycle, because
  // both are decoded purely from the state and the word register, neither of
  // which changes while a send state waits for tx_ready.

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  tx_state_t         state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   cnt_total_q, cnt_total_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        lat_q, lat_d;
  logic [ADDR_W:0]   idx_inc;
  logic              lat_last;

  assign idx_inc  = idx_q + 1'b1;
  assign lat_last = (lat_q == LAT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_total_q <= '0;
      word_q      <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_total_q <= cnt_total_d;
      word_q      <= word_d;
      lat_q       <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_words == '0) ? END_LO : RD_REQ;
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: if (lat_last) state_d = SEND_LO;
      SEND_LO: if (tx_ready) state_d = SEND_HI;
      SEND_HI: if (tx_ready) state_d = (idx_inc == cnt_total_q) ? END_LO : RD_REQ;
      END_LO:  if (tx_ready) state_d = END_HI;
      END_HI:  if (tx_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word counter, latched total, read-latency counter and captured word.
  always_comb begin
    idx_d       = idx_q;
    cnt_total_d = cnt_total_q;
    word_d      = word_q;
    lat_d       = lat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_total_d = num_words;
          idx_d       = '0;
        end
      end
      RD_REQ:  lat_d = '0;
      RD_WAIT: begin
        if (lat_last) word_d = bram_rdata;
        else          lat_d  = lat_q + 2'd1;
      end
      SEND_HI: if (tx_ready) idx_d = idx_inc;
      default: ;
    endcase
  end

  always_comb begin
    bram_en  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    case (state_q)
      RD_REQ:  bram_en = 1'b1;
      SEND_LO: begin
        tx_valid = 1'b1;
        tx_data  = lo_byte(word_q);
      end
      SEND_HI: begin
        tx_valid = 1'b1;
        tx_data  = hi_byte(word_q);
      end
      END_LO, END_HI: begin
        tx_valid = 1'b1;
        tx_data  = END_MARKER;
      end
      default: ;
    endcase
  end

  assign bram_addr = idx_q[ADDR_W-1:0];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fsm_split_tx.sv
// Bench for fsm_split_tx: randomized runs against a byte-stream model, with a
// scoreboard monitor checking order, hold-while-stalled, gaps and done.
module tb_fsm_split_tx;
  import vec_uart_pkg::*;

  localparam int ADDR_W = 10;
  localparam int EW     = 11; // {hi_data, gap_check, last, byte}

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic              start, bram_en, tx_valid, tx_ready, busy, done;
  logic [ADDR_W:0]   num_words;
  logic [ADDR_W-1:0] bram_addr;
  logic [9:0]        bram_rdata;
  logic [7:0]        tx_data;
  tx_state_t         state_dbg;

  logic              start2, bram_en2, tx_valid2, tx_ready2, busy2, done2;
  logic [ADDR_W:0]   num_words2;
  logic [ADDR_W-1:0] bram_addr2;
  logic [9:0]        bram_rdata2, pipe2;
  logic [7:0]        tx_data2;
  tx_state_t         state_dbg2;

  fsm_split_tx #(.ADDR_W(ADDR_W), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_rdata(bram_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  fsm_split_tx #(.ADDR_W(ADDR_W), .RD_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .num_words(num_words2),
    .bram_en(bram_en2), .bram_addr(bram_addr2), .bram_rdata(bram_rdata2),
    .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready2),
    .busy(busy2), .done(done2), .state_dbg(state_dbg2)
  );

  logic [9:0] mem  [1024];
  logic [9:0] mem2 [1024];

  always @(posedge clk) if (bram_en) bram_rdata <= mem[bram_addr];
  always @(posedge clk) begin
    if (bram_en2) pipe2 <= mem2[bram_addr2];
    bram_rdata2 <= pipe2;
  end

  logic [EW-1:0] exp_q[$];
  logic [7:0]    exp2_q[$];
  int n_vec = 0, n_err = 0;
  int done_cnt = 0, done_exp = 0, en_cnt = 0, en_exp = 0, xfer_cnt = 0;
  int done_cnt2 = 0;
  logic rand_ready = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int act);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected value 0x%0h", name, act);
  endtask

  // Model: every word becomes low byte then high byte, then two 0xFF bytes.
  task automatic push_run(input int n);
    for (int i = 0; i < n; i++) begin
      int   w;
      logic g;
      w = int'(mem[i]);
      g = (i > 0);
      exp_q.push_back({1'b0, g, 1'b0, 8'(w % 256)});
      exp_q.push_back({1'b1, 1'b0, 1'b0, 8'(w / 256)});
    end
    exp_q.push_back({3'b000, 8'hFF});
    exp_q.push_back({3'b001, 8'hFF});
    done_exp++;
    en_exp += n;
  endtask

  task automatic do_start(input int n, input bit accepted);
    @(posedge clk); #1;
    if (accepted) push_run(n);
    start     = 1'b1;
    num_words = (ADDR_W+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int c;
    c = 0;
    while (!(exp_q.size() == 0 && !busy) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk({name, "_finished"}, (c < budget) ? 1 : 0, 1);
    chk({name, "_busy_low"}, busy, 0);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int c;
    c = 0;
    while (!tx_valid && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk({name, "_valid_seen"}, (c < budget) ? 1 : 0, 1);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) mem[i] = 10'($urandom_range(0, 1023));
  endtask

  always @(posedge clk) begin
    #2;
    if (rand_ready) tx_ready = ($urandom_range(0, 99) < 60);
  end

  // Monitor / scoreboard for the latency-1 instance.
  int            cyc = 0, valid_start = 0, last_hi_cyc = 0;
  logic          prev_valid = 1'b0, prev_xfer = 1'b0, prev_stall = 1'b0, expect_done = 1'b0;
  logic [7:0]    prev_data = '0;
  logic [EW-1:0] e;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_valid  = 1'b0;
      prev_xfer   = 1'b0;
      prev_stall  = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (expect_done) begin
        chk("done_pulse", done, 1);
        expect_done = 1'b0;
      end else if (done) begin
        flag("done_unexpected", done);
      end
      if (done) done_cnt++;
      if (bram_en) en_cnt++;
      if (prev_stall) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, prev_data);
      end
      if (tx_valid && (!prev_valid || prev_xfer)) valid_start = cyc;
      if (tx_valid && tx_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          flag("extra_byte", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", tx_data, e[7:0]);
          if (e[9]) chk("word_gap", valid_start - last_hi_cyc, 3);
          if (e[10]) last_hi_cyc = cyc;
          if (e[8]) expect_done = 1'b1;
        end
      end
      prev_valid = tx_valid;
      prev_xfer  = tx_valid && tx_ready;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  always @(negedge clk) begin
    if (!reset && done2) done_cnt2++;
    if (!reset && tx_valid2 && tx_ready2) begin
      if (exp2_q.size() == 0) flag("lat2_extra_byte", tx_data2);
      else chk("lat2_byte", tx_data2, exp2_q.pop_front());
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int en_before, x_before, c;
    reset = 1'b1; start = 1'b0; num_words = '0; tx_ready = 1'b0;
    start2 = 1'b0; num_words2 = '0; tx_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_state", int'(state_dbg), int'(IDLE));
    chk("rst_tx_valid2", tx_valid2, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Three words, receiver always ready.
    mem[0] = 10'h155; mem[1] = 10'h2AA; mem[2] = 10'h3FF;
    tx_ready = 1'b1;
    do_start(3, 1);
    wait_end("three_words", 100);
    chk("three_words_done_cnt", done_cnt, 1);

    // Empty run: terminator only, no BRAM reads.
    en_before = en_cnt;
    do_start(0, 1);
    wait_end("zero_words", 50);
    chk("zero_words_no_bram_en", en_cnt, en_before);

    // Two words under random backpressure.
    fill_random(2);
    rand_ready = 1'b1;
    do_start(2, 1);
    wait_end("backpressure", 400);

    // Restart attempts during an active run must be ignored.
    fill_random(4);
    do_start(4, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("restart_busy_a", busy, 1);
    do_start(7, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("restart_busy_b", busy, 1);
    do_start(1, 0);
    wait_end("restart", 800);

    // Reset while the high byte of word 1 is stalled.
    rand_ready = 1'b0;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    fill_random(4);
    x_before = xfer_cnt;
    do_start(4, 1);
    for (int p = 0; p < 3; p++) begin
      wait_valid("rst_mid_pulse", 20);
      tx_ready = 1'b1;
      @(posedge clk); #1;
      tx_ready = 1'b0;
    end
    wait_valid("rst_mid_hi", 20);
    chk("rst_mid_xfers", xfer_cnt - x_before, 3);
    chk("rst_mid_state", int'(state_dbg), int'(SEND_HI));
    reset = 1'b1;
    exp_q.delete();
    done_exp--;
    en_exp -= 2;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_tx_valid", tx_valid, 0);
    chk("rst_mid_busy", busy, 0);
    tx_ready = 1'b1;
    repeat (10) @(posedge clk);
    fill_random(1);
    do_start(1, 1);
    wait_end("after_reset", 50);

    // Latency-2 instance: first valid exactly four cycles after start.
    mem2[0] = 10'h2C3;
    @(posedge clk); #1;
    exp2_q.push_back(8'hC3); exp2_q.push_back(8'h02);
    exp2_q.push_back(8'hFF); exp2_q.push_back(8'hFF);
    start2 = 1'b1; num_words2 = 11'd1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) start2 = 1'b0;
      chk("lat2_first_valid", tx_valid2, (k == 4) ? 1 : 0);
    end
    c = 0;
    while (!(exp2_q.size() == 0 && !busy2) && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk("lat2_finished", (c < 50) ? 1 : 0, 1);
    chk("lat2_done_cnt", done_cnt2, 1);

    // Random runs under random backpressure.
    rand_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 6);
      fill_random(n);
      do_start(n, 1);
      wait_end("random_run", 600);
    end

    // Full address space: 2^ADDR_W words.
    rand_ready = 1'b0;
    @(posedge clk); #1;
    tx_ready = 1'b1;
    fill_random(1024);
    do_start(1024, 1);
    wait_end("full_depth", 6000);

    chk("total_done_pulses", done_cnt, done_exp);
    chk("total_bram_reads", en_cnt, en_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
